// File: rtl/am29_mpa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : am29_mpa_pkg
//  Purpose  : Shared definitions for lookahead-aware multi-precision
//             arithmetic controllers: mode encodings, sequencer states and
//             the word carry-out equation built from the group G/P outputs.
//  Revision : 1.0  initial release
// ============================================================================
package am29_mpa_pkg;

  // Operation modes, sampled together with start
  localparam logic [1:0] MODE_ADD = 2'b00;  // cin = 0
  localparam logic [1:0] MODE_SUB = 2'b01;  // cin = 1 (A + ~B + 1)
  localparam logic [1:0] MODE_ADC = 2'b10;  // cin = previous carry flag
  localparam logic [1:0] MODE_SBC = 2'b11;  // cin = previous carry flag

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Carry out of a slice group from its active-low generate/propagate
  // outputs and the carry presented to it.
  function automatic logic carry4(input logic g_n, input logic p_n,
                                  input logic cin);
    return ~g_n | (~p_n & cin);
  endfunction

  // Carry into the least-significant word for a given mode. The extended
  // modes reuse the raw carry flag unchanged; for subtraction that flag is
  // already the inverted borrow.
  function automatic logic mode_cin(input logic [1:0] mode, input logic cflag);
    logic cin;
    case (mode)
      MODE_ADD: cin = 1'b0;
      MODE_SUB: cin = 1'b1;
      default:  cin = cflag;
    endcase
    return cin;
  endfunction

endpackage
`default_nettype wire

// File: rtl/am29_mpa_seq.sv
`default_nettype none
// ============================================================================
//  Module   : am29_mpa_seq
//  Purpose  : Steps an NWORDS-word add/subtract through a bitslice ALU group,
//             LSW first, one word per clock. Supplies the group carry-in,
//             chains the lookahead-derived carry-out into the next word and
//             posts carry/zero/overflow flags on completion.
//  Revision : 1.0  initial release
// ============================================================================
module am29_mpa_seq #(
  parameter int NWORDS = 4,   // words per operation, 2..16
  parameter int IW     = 4    // word index width, NWORDS <= 2**IW
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic          go_,
  input  logic          po_,
  input  logic          zero,
  input  logic          ovr,
  output logic [IW-1:0] widx,
  output logic          cn,
  output logic          we,
  output logic          busy,
  output logic          done,
  output logic          cflag,
  output logic          zflag,
  output logic          vflag
);

  import am29_mpa_pkg::*;

  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  state_t state;
  logic   creg;     // carry into the word currently in the slices
  logic   zacc;     // all words so far were zero
  logic   c4;       // carry out of the current word

  // Carry-out of the current word; the slices respond to cn within the cycle
  assign c4 = carry4(go_, po_, creg);

  // creg is zero outside RUN, so it serves directly as the registered cn
  assign cn = creg;

  // Sequencer: state, word counter, carry chain, zero accumulator and flags
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= IDLE;
      widx  <= '0;
      creg  <= 1'b0;
      zacc  <= 1'b0;
      we    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      cflag <= 1'b0;
      zflag <= 1'b0;
      vflag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            creg  <= mode_cin(mode, cflag);
            widx  <= '0;
            zacc  <= 1'b1;
            we    <= 1'b1;
            busy  <= 1'b1;
          end
        end

        RUN: begin
          if (widx == LAST_IDX) begin
            // Final word: its carry goes to the flag, not back into the chain
            state <= DONE;
            creg  <= 1'b0;
            cflag <= c4;
            zflag <= zacc & zero;
            vflag <= ovr;
            we    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            creg <= c4;
            zacc <= zacc & zero;
            widx <= widx + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          widx  <= '0;
          done  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          widx  <= '0;
          creg  <= 1'b0;
          we    <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_am29_mpa_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_am29_mpa_seq
//  Purpose  : Bench for am29_mpa_seq with a 4x4-bit slice datapath model per
//             16-bit word producing real group G/P, and a scoreboard of
//             expected per-word carries/results and completion flags.
//  Revision : 1.0  initial release
// ============================================================================
module tb_am29_mpa_seq;

  import am29_mpa_pkg::*;

  localparam int NW = 4;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_;
  logic          start;
  logic [1:0]    mode;
  logic          go_, po_, zero, ovr;
  logic [IW-1:0] widx;
  logic          cn, we, busy, done, cflag, zflag, vflag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  am29_mpa_seq #(.NWORDS(NW), .IW(IW)) dut (
    .clk(clk), .rst_(rst_), .start(start), .mode(mode),
    .go_(go_), .po_(po_), .zero(zero), .ovr(ovr),
    .widx(widx), .cn(cn), .we(we), .busy(busy), .done(done),
    .cflag(cflag), .zflag(zflag), .vflag(vflag)
  );

  // ---------------- slice datapath model ----------------
  logic [63:0] opa, opb;
  logic        sub_op;
  logic [15:0] aw, bw, rw;
  logic [16:0] sum17;
  logic [3:0]  sa, sb;
  logic        gs, ps, gg, pp;

  always_comb begin
    aw = 16'(opa >> (32'(widx) * 16));
    bw = 16'(opb >> (32'(widx) * 16));
    if (sub_op) bw = ~bw;
    gg = 1'b0; pp = 1'b1; sa = '0; sb = '0; gs = 1'b0; ps = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sa = aw[4*s +: 4];
      sb = bw[4*s +: 4];
      gs = ({1'b0, sa} + {1'b0, sb}) > 5'd15;
      ps = (sa | sb) == 4'hF;
      gg = gs | (ps & gg);
      pp = pp & ps;
    end
    go_   = ~gg;
    po_   = ~pp;
    sum17 = {1'b0, aw} + {1'b0, bw} + 17'(cn);
    rw    = sum17[15:0];
    zero  = (rw == 16'h0);
    ovr   = (aw[15] == bw[15]) && (rw[15] != aw[15]);
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic [IW-1:0] idx; logic c; logic [15:0] word; } wexp_t;
  typedef struct { logic c; logic z; logic v; } fexp_t;
  wexp_t wq[$];
  fexp_t fq[$];
  logic  m_c = 1'b0, m_z = 1'b0, m_v = 1'b0;   // model of the flags

  task automatic push_expected(input logic [1:0] md, input logic [63:0] a,
                               input logic [63:0] b);
    logic        cin;
    logic [63:0] be;
    logic [64:0] full, part, msk;
    wexp_t       e;
    fexp_t       f;
    cin  = (md == MODE_ADD) ? 1'b0 : (md == MODE_SUB) ? 1'b1 : m_c;
    be   = md[0] ? ~b : b;
    full = {1'b0, a} + {1'b0, be} + 65'(cin);
    for (int i = 0; i < NW; i++) begin
      msk    = (65'd1 << (16 * i)) - 65'd1;
      part   = ({1'b0, a} & msk) + ({1'b0, be} & msk) + 65'(cin);
      e.idx  = IW'(i);
      e.c    = part[16*i];
      e.word = full[16*i +: 16];
      wq.push_back(e);
    end
    f.c = full[64];
    f.z = (full[63:0] == 64'h0);
    f.v = (a[63] == be[63]) && (full[63] != a[63]);
    fq.push_back(f);
    m_c = f.c; m_z = f.z; m_v = f.v;
  endtask

  // Pops expected word data on each write strobe and flags on each done
  always @(negedge clk) begin
    if (rst_ === 1'b1 && we === 1'b1) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_we: widx=%0d with no expected word", widx);
      end else begin
        wexp_t e;
        e = wq.pop_front();
        checks++;
        if (widx !== e.idx) begin
          errors++;
          $display("FAIL word_idx: got %0d expected %0d", widx, e.idx);
        end
        checks++;
        if (cn !== e.c) begin
          errors++;
          $display("FAIL word_cn[%0d]: got %b expected %b", e.idx, cn, e.c);
        end
        checks++;
        if (rw !== e.word) begin
          errors++;
          $display("FAIL word_result[%0d]: got %h expected %h", e.idx, rw, e.word);
        end
      end
    end
    if (rst_ === 1'b1 && done === 1'b1) begin
      if (fq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: no expected flags");
      end else begin
        fexp_t f;
        f = fq.pop_front();
        checks++;
        if ({cflag, zflag, vflag} !== {f.c, f.z, f.v}) begin
          errors++;
          $display("FAIL flags: got c=%b z=%b v=%b expected c=%b z=%b v=%b",
                   cflag, zflag, vflag, f.c, f.z, f.v);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ = 1'b0; start = 1'b0; mode = MODE_ADD;
    opa = '0; opb = '0; sub_op = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({widx, cn, we, busy, done, cflag, zflag, vflag} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got widx=%0d cn=%b we=%b busy=%b done=%b c=%b z=%b v=%b expected all 0",
               widx, cn, we, busy, done, cflag, zflag, vflag);
    end
    @(posedge clk); #1 rst_ = 1'b1;
  endtask

  // One operation: flags must hold through RUN, done after NW+1 cycles
  task automatic run_op(input logic [1:0] md, input logic [63:0] a,
                        input logic [63:0] b, input string name);
    logic pc, pz, pv;
    int   n;
    logic got;
    @(posedge clk); #1;
    opa = a; opb = b; sub_op = md[0]; mode = md; start = 1'b1;
    pc = m_c; pz = m_z; pv = m_v;
    push_expected(md, a, b);
    @(posedge clk); #1 start = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
      else if (busy) begin
        checks++;
        if ({cflag, zflag, vflag} !== {pc, pz, pv}) begin
          errors++;
          $display("FAIL %s_flag_hold: got %b%b%b expected %b%b%b", name,
                   cflag, zflag, vflag, pc, pz, pv);
        end
      end
    end
    checks++;
    if (!got || n != NW + 1) begin
      errors++;
      $display("FAIL %s_done_latency: got %0d cycles (seen=%b) expected %0d",
               name, n, got, NW + 1);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || we !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_done: got done=%b busy=%b we=%b expected 0 0 0",
               name, done, busy, we);
    end
  endtask

  task automatic test_back_to_back();
    int acc[3];
    int nacc, cyc;
    @(posedge clk); #1;
    opa = '0; opb = '0; sub_op = 1'b0; mode = MODE_ADD; start = 1'b1;
    for (int i = 0; i < 3; i++) push_expected(MODE_ADD, 64'h0, 64'h0);
    nacc = 0; cyc = 0;
    while (nacc < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy && widx == '0) begin
        acc[nacc] = cyc;
        nacc++;
        if (nacc == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (nacc != 3 || acc[1] - acc[0] != NW + 2 || acc[2] - acc[1] != NW + 2) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d starts at %0d,%0d,%0d expected 3 spaced %0d",
               nacc, acc[0], acc[1], acc[2], NW + 2);
    end
    cyc = 0;
    while (!done && cyc < 10) begin @(negedge clk); cyc++; end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    int n;
    @(posedge clk); #1;
    opa = 64'h1111_2222_3333_4444; opb = 64'h0101_0202_0303_0404;
    sub_op = 1'b0; mode = MODE_ADD; start = 1'b1;
    push_expected(MODE_ADD, opa, opb);
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (!(busy && widx == IW'(2)) && n < 10) begin @(negedge clk); n++; end
    #2 rst_ = 1'b0;
    #1;
    checks++;
    if ({widx, cn, we, busy, done, cflag, zflag, vflag} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: got widx=%0d cn=%b we=%b busy=%b done=%b c=%b z=%b v=%b expected all 0",
               widx, cn, we, busy, done, cflag, zflag, vflag);
    end
    wq.delete(); fq.delete();
    m_c = 1'b0; m_z = 1'b0; m_v = 1'b0;
    @(posedge clk); #1 rst_ = 1'b1;
    run_op(MODE_ADD, 64'h0000_0000_8000_FFFF, 64'h0000_0000_8000_0001, "post_reset");
  endtask

  initial begin
    test_reset();
    run_op(MODE_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, "add_carry");
    run_op(MODE_ADC, 64'h0, 64'h0, "adc");
    run_op(MODE_SUB, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0005, "sub");
    test_reset_midrun();
    run_op(MODE_ADD, 64'h7FFF_0000_0000_0000, 64'h0001_0000_0000_0000, "add_ovf");
    run_op(MODE_SBC, 64'h0000_0000_0001_0000, 64'h0000_0000_0000_0001, "sbc");
    test_back_to_back();
    checks++;
    if (wq.size() != 0 || fq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d words %0d flags left expected 0 0",
               wq.size(), fq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
